// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use bubbles, branch flushes
// and a memory-wait freeze with timeout watchdog. Define HAZARD_PERF_EN to add performance counters.
module hazard_ctrl_unit #(
  parameter int AW          = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 8,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addrD,
  input  logic [AW-1:0] rs2_addrD,
  input  logic [AW-1:0] rs1_addrE,
  input  logic [AW-1:0] rs2_addrE,
  input  logic [AW-1:0] rd_addrE,
  input  logic [AW-1:0] rd_addrM,
  input  logic [AW-1:0] rd_addrW,
  input  logic          rd_wrenE,
  input  logic          rd_wrenM,
  input  logic          rd_wrenW,
  input  logic          wb_selE,
  input  logic          wb_selM,
  input  logic          br_selE,
  input  logic          dmem_ready,
  output logic [1:0]    ex1_sel,
  output logic [1:0]    ex2_sel,
  output logic          rs1d_sel,
  output logic          rs2d_sel,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          flushD,
  output logic          flushE,
  output logic          flushW,
  output logic          mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_lu_cnt
`endif
);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > (2**TW) - 1 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl_unit: illegal parameter combination");
  end

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] wait_cnt, wait_cnt_nxt;
  logic          mem_err_nxt;
  logic          mw, lu, lu_apply;

  assign mw       = wb_selM & ~dmem_ready;
  assign lu       = wb_selE & rd_wrenE & (rd_addrE != '0) &
                    ((rd_addrE == rs1_addrD) | (rd_addrE == rs2_addrD));
  // A frozen pipe or a squashed D instruction makes the load-use bubble moot.
  assign lu_apply = lu & ~mw & ~br_selE;

  always_comb begin
    ex1_sel = 2'b00;
    if (rs1_addrE != '0) begin
      if (rd_wrenM && rd_addrM == rs1_addrE) ex1_sel = wb_selM ? 2'b11 : 2'b01;
      else if (rd_wrenW && rd_addrW == rs1_addrE) ex1_sel = 2'b10;
    end
  end

  always_comb begin
    ex2_sel = 2'b00;
    if (rs2_addrE != '0) begin
      if (rd_wrenM && rd_addrM == rs2_addrE) ex2_sel = wb_selM ? 2'b11 : 2'b01;
      else if (rd_wrenW && rd_addrW == rs2_addrE) ex2_sel = 2'b10;
    end
  end

  assign rs1d_sel = rd_wrenW & (rd_addrW == rs1_addrD) & (rs1_addrD != '0);
  assign rs2d_sel = rd_wrenW & (rd_addrW == rs2_addrD) & (rs2_addrD != '0);

  assign stallF = mw | lu_apply;
  assign stallD = mw | lu_apply;
  assign stallE = mw;
  assign stallM = mw;
  assign flushW = mw;
  assign flushD = br_selE & ~mw;
  assign flushE = (br_selE | lu_apply) & ~mw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  // On timeout the FSM drops back to IDLE; the stall persists, so counting restarts.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    case (state)
      IDLE: begin
        if (mw) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (!mw) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
          mem_err_nxt  = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(stallF);
      perf_flush_cnt <= perf_flush_cnt + CNT_W'(flushD);
      perf_lu_cnt    <= perf_lu_cnt + CNT_W'(lu_apply);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios plus random traffic against a reference model.
module tb_hazard_ctrl_unit;
  localparam int AW = 5;
  localparam int TO = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_addrM, rd_addrW;
  logic          rd_wrenE, rd_wrenM, rd_wrenW, wb_selE, wb_selM, br_selE, dmem_ready;
  logic [1:0]    ex1_sel, ex2_sel;
  logic          rs1d_sel, rs2d_sel, stallF, stallD, stallE, stallM;
  logic          flushD, flushE, flushW, mem_err;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_lu_cnt;
`endif

  hazard_ctrl_unit #(.AW(AW), .MEM_TIMEOUT(TO), .TW(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD), .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE),
    .rd_addrE(rd_addrE), .rd_addrM(rd_addrM), .rd_addrW(rd_addrW),
    .rd_wrenE(rd_wrenE), .rd_wrenM(rd_wrenM), .rd_wrenW(rd_wrenW),
    .wb_selE(wb_selE), .wb_selM(wb_selM), .br_selE(br_selE), .dmem_ready(dmem_ready),
    .ex1_sel(ex1_sel), .ex2_sel(ex2_sel), .rs1d_sel(rs1d_sel), .rs2d_sel(rs2d_sel),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_lu_cnt(perf_lu_cnt)
`endif
  );

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          wrenE, wrenM, wrenW, wbE, wbM, br, ready;
  } stim_t;

  // {ex1[13:12], ex2[11:10], rs1d, rs2d, stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err}
  typedef logic [13:0] resp_t;

  resp_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cycle = 0;
  bit    model_err = 1'b0;
  int    run = 0;
  int    m_stall = 0, m_flush = 0, m_lu = 0;
  stim_t s;

  function automatic logic [1:0] ref_fwd(input stim_t t, input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (t.wrenM && t.rdM == src) return t.wbM ? 2'b11 : 2'b01;
    if (t.wrenW && t.rdW == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic resp_t ref_model(input stim_t t, input bit err);
    logic mw, lu, b1, b2;
    logic [6:0] ctl;
    mw = t.wbM & ~t.ready;
    lu = t.wbE & t.wrenE & (t.rdE != 0) & ((t.rdE == t.rs1D) | (t.rdE == t.rs2D));
    b1 = t.wrenW && (t.rdW == t.rs1D) && (t.rs1D != 0);
    b2 = t.wrenW && (t.rdW == t.rs2D) && (t.rs2D != 0);
    // ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    if (mw)        ctl = 7'b1111_001;
    else if (t.br) ctl = 7'b0000_110;
    else if (lu)   ctl = 7'b1100_010;
    else           ctl = 7'b0000_000;
    return {ref_fwd(t, t.rs1E), ref_fwd(t, t.rs2E), b1, b2, ctl, err};
  endfunction

  task automatic applyStimulus(input stim_t t);
    resp_t e;
    rst = t.rst; rs1_addrD = t.rs1D; rs2_addrD = t.rs2D; rs1_addrE = t.rs1E; rs2_addrE = t.rs2E;
    rd_addrE = t.rdE; rd_addrM = t.rdM; rd_addrW = t.rdW;
    rd_wrenE = t.wrenE; rd_wrenM = t.wrenM; rd_wrenW = t.wrenW;
    wb_selE = t.wbE; wb_selM = t.wbM; br_selE = t.br; dmem_ready = t.ready;
    e = ref_model(t, model_err);
    exp_q.push_back(e);
    @(posedge clk);
    if (t.rst) begin
      model_err = 1'b0; run = 0; m_stall = 0; m_flush = 0; m_lu = 0;
    end else begin
      if (t.wbM && !t.ready) begin
        run++;
        if (run == TO) begin model_err = 1'b1; run = 0; end
      end else begin
        run = 0;
      end
      m_stall += int'(e[7]);
      m_flush += int'(e[3]);
      m_lu    += int'(e[7] & ~e[5]);
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      resp_t e;
      e = exp_q.pop_front();
      cycle++;
      checkOutput($sformatf("outputs cycle %0d", cycle),
                  64'({ex1_sel, ex2_sel, rs1d_sel, rs2d_sel, stallF, stallD, stallE, stallM,
                       flushD, flushE, flushW, mem_err}), 64'(e));
    end
  end

  initial begin
    rst = 1'b1;
    {rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_addrM, rd_addrW} = '0;
    {rd_wrenE, rd_wrenM, rd_wrenW, wb_selE, wb_selM, br_selE, dmem_ready} = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state with idle inputs
    s = '0; s.rst = 1'b1; applyStimulus(s);
    s = '0; applyStimulus(s); applyStimulus(s);

    // forwarding priority
    s = '0; s.rs1E = 3; s.rdM = 3; s.wrenM = 1; s.rdW = 3; s.wrenW = 1; s.ready = 1;
    applyStimulus(s);
    s.wbM = 1; applyStimulus(s);
    s.rs2E = 3; s.rs1E = 0; applyStimulus(s);
    s.wrenM = 0; s.rs1D = 3; applyStimulus(s);

    // load-use, then rd = x0, then load-use masked by branch
    s = '0; s.ready = 1; s.wbE = 1; s.wrenE = 1; s.rdE = 5; s.rs2D = 5;
    applyStimulus(s);
    s.rdE = 0; s.rs2D = 0; applyStimulus(s);
    s.rdE = 5; s.rs2D = 5; s.br = 1; applyStimulus(s);

    // memory wait with a pending branch, then release
    s = '0; s.br = 1; s.wbM = 1; s.wrenM = 1; s.rdM = 7;
    repeat (4) applyStimulus(s);
    s.ready = 1; applyStimulus(s);
    s = '0; s.rst = 1; applyStimulus(s);

    // timeout: long wait, then idle, then reset clears the flag
    s = '0; s.wbM = 1; s.wrenM = 1; s.rdM = 2;
    repeat (10) applyStimulus(s);
    s = '0; repeat (2) applyStimulus(s);
    s.rst = 1; applyStimulus(s);
    s = '0; applyStimulus(s);

    // random traffic with small addresses so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 59) == 0);
      s.rs1D  = AW'($urandom_range(0, 3)); s.rs2D = AW'($urandom_range(0, 3));
      s.rs1E  = AW'($urandom_range(0, 3)); s.rs2E = AW'($urandom_range(0, 3));
      s.rdE   = AW'($urandom_range(0, 3)); s.rdM  = AW'($urandom_range(0, 3));
      s.rdW   = AW'($urandom_range(0, 3));
      s.wrenE = 1'($urandom); s.wrenM = 1'($urandom); s.wrenW = 1'($urandom);
      s.wbE   = 1'($urandom); s.wbM = ($urandom_range(0, 2) == 0);
      s.br    = ($urandom_range(0, 4) == 0);
      s.ready = ($urandom_range(0, 3) != 0);
      applyStimulus(s);
    end

`ifdef HAZARD_PERF_EN
    // three load-use events and two memory-wait cycles after a reset
    s = '0; s.rst = 1; applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = '0; s.ready = 1; s.wbE = 1; s.wrenE = 1; s.rdE = 6; s.rs1D = 6; applyStimulus(s);
      s = '0; applyStimulus(s);
    end
    s = '0; s.wbM = 1; repeat (2) applyStimulus(s);
    checkOutput("perf_lu_cnt", 64'(perf_lu_cnt), 64'(m_lu));
    checkOutput("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
    checkOutput("perf_flush_cnt", 64'(perf_flush_cnt), 64'(m_flush));
    s = '0; s.rst = 1; applyStimulus(s);
    checkOutput("perf_cnt after reset", 64'({perf_lu_cnt, perf_stall_cnt}), 64'({m_lu[CW-1:0], m_stall[CW-1:0]}));
`endif

    s = '0; applyStimulus(s);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage core (F/D/E/M/W). It replaces the purely combinational forwarding/load-use logic with the following:
- E-stage operand forwarding from M (ALU result or load data), with W forwarding below it.
- W→D register-file bypass.
- Load-use bubble insertion.
- Taken-branch flush.
- A memory-wait FSM that freezes the pipe while the data memory is not ready, with a timeout watchdog.

It sits beside the datapath and drives all stage stall/flush enables and operand mux selects.

Parameters:
AW, 5, register address width (2^AW architectural registers; address 0 is hard-wired zero).
MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before mem_err is set (legal range 2..2^TW-1).
TW, 8, width of the wait counter.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  core clock
rst  in  1  reset
rs1_addrD  in  AW  D-stage source 1
rs2_addrD  in  AW  D-stage source 2
rs1_addrE  in  AW  E-stage source 1
rs2_addrE  in  AW  E-stage source 2
rd_addrE  in  AW  E-stage destination
rd_addrM  in  AW  M-stage destination
rd_addrW  in  AW  W-stage destination
rd_wrenE  in  1  E writes rd
rd_wrenM  in  1  M writes rd
rd_wrenW  in  1  W writes rd
wb_selE  in  1  E instruction is a load
wb_selM  in  1  M instruction is a load
br_selE  in  1  branch/jump taken, resolved in E
dmem_ready  in  1  data memory read data valid this cycle (meaningful only when wb_selM=1)
ex1_sel  out  2  E operand-1 mux: 00 regfile, 01 M ALU result, 10 W result, 11 M load data
ex2_sel  out  2  same encoding for operand 2
rs1d_sel  out  1  D operand-1 takes W result (write-through bypass)
rs2d_sel  out  1  D operand-2 takes W result
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
stallM  out  1  hold E/M register
flushD  out  1  bubble F/D register
flushE  out  1  bubble D/E register
flushW  out  1  bubble M/W register
mem_err  out  1  sticky memory-timeout flag

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high.
- On reset: FSM enters IDLE, wait_cnt clears to 0, mem_err clears to 0.
- Every output is combinational from the inputs plus the registered state. With all inputs 0, every output is 0.

Forwarding (per E source; shown for src1, identical for src2):
- If rs1_addrE == 0: ex1_sel = 00.
- Else if rd_wrenM and rd_addrM == rs1_addrE: ex1_sel = 11 if wb_selM, otherwise 01.
- Else if rd_wrenW and rd_addrW == rs1_addrE: ex1_sel = 10.
- Else ex1_sel = 00.
- M always has priority over W.

D bypass:
- rs1d_sel = rd_wrenW & (rd_addrW == rs1_addrD) & (rs1_addrD != 0). rs2d_sel is the same for source 2.

Load-use hazard:
- Condition: lu = wb_selE & rd_wrenE & (rd_addrE != 0) & (rd_addrE == rs1_addrD | rd_addrE == rs2_addrD).
- Response: stallF = 1, stallD = 1, flushE = 1 for exactly the cycle lu is high.
- The dependent instruction then reaches E while the load is in M and is served with 11.

Memory wait:
- Condition: mw = wb_selM & ~dmem_ready.
- Response: stallF = stallD = stallE = stallM = 1 and flushW = 1.
- While mw is high, flushD, flushE and the load-use response are all suppressed (a frozen pipe must not be squashed).

Branch:
- When br_selE & ~mw: flushD = 1, flushE = 1, and the load-use response is suppressed (the D instruction is being discarded).

Priority: mw > br_selE > lu.

FSM (IDLE, MEM_WAIT):
- IDLE: if mw, go to MEM_WAIT with wait_cnt = 1.
- MEM_WAIT: if ~mw, go to IDLE with wait_cnt = 0. Otherwise wait_cnt increments.
- Timeout: if wait_cnt == MEM_TIMEOUT-1 while mw, set mem_err, go to IDLE, clear wait_cnt. Stalls continue because mw is still high, so the count restarts.
- mem_err stays set until rst.
- rst asserted mid-wait aborts the wait immediately; the next cycle's outputs reflect only the inputs.

Optional Feature:
Macro: HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt, perf_flush_cnt and perf_lu_cnt (each CNT_W wide).
  - perf_stall_cnt increments each cycle stallF = 1.
  - perf_flush_cnt increments each cycle flushD = 1.
  - perf_lu_cnt increments each cycle the load-use response is actually applied.
  - All three wrap modulo 2^CNT_W and clear on rst.
- Undefined: the ports and registers are absent. All other behaviour is identical.

Test Plan:
- Forwarding: rs1_addrE = 3, rd_addrM = 3, rd_wrenM = 1, wb_selM = 0, rd_addrW = 3, rd_wrenW = 1 → ex1_sel = 01. Set wb_selM = 1, dmem_ready = 1 → ex1_sel = 11. Set rs1_addrE = 0 → 00.
- Load-use: wb_selE = 1, rd_wrenE = 1, rd_addrE = 5, rs2_addrD = 5 for 1 cycle → stallF = stallD = flushE = 1 for that cycle only. rd_addrE = 0 → no stall.
- Branch vs load-use: the load-use condition above plus br_selE = 1 → flushD = flushE = 1, stallF = stallD = 0.
- Memory wait: wb_selM = 1, dmem_ready = 0 for 4 cycles then 1, with br_selE = 1 throughout → stallF/D/E/M = 1 and flushW = 1 for 4 cycles, flushD = 0. On the 5th cycle, stalls drop, flushD = 1, FSM is back in IDLE.
- Timeout: MEM_TIMEOUT = 4, hold mw for 10 cycles → mem_err rises after the 4th wait cycle and stays 1 after mw ends. rst → mem_err = 0.
- HAZARD_PERF_EN defined: 3 load-use events plus 2 memory-wait cycles → perf_lu_cnt = 3, perf_stall_cnt = 5. rst → all counters 0.
